pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised next-generation program-counter unit for the RV32I core.
- Holds the fetch PC and the previous PC, and resolves redirects from branch, jal and jalr.
- Freezes on data-memory or instruction-memory back-pressure and detects misaligned control-flow targets.
- Sits between the decode/execute redirect logic and the instruction-memory address port; replaces the single-cycle PC register.

Parameters:
- XLEN, 32, width of every address port and internal PC register.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits).
- STEP, 4, byte increment for sequential fetch (4 = RV32I, 2 = compressed fetch).
- C_EXT, 0: 0 = targets must be 4-byte aligned; 1 = 2-byte alignment permitted.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-low reset
- stall  in  1  data-side stall (load waiting on dmem_valid); freezes PC and previous PC
- imem_ready  in  1  instruction memory accepted current pc_o
- br_taken  in  1  branch resolved taken
- br_target  in  XLEN  branch target
- jal  in  1  jal redirect
- jal_target  in  XLEN  jal target
- jalr  in  1  jalr redirect
- jalr_target  in  XLEN  jalr target (bit 0 forced to 0 internally)
- pc_o  out  XLEN  current fetch PC
- pc_prev_o  out  XLEN  PC of the previously fetched instruction
- pc_valid_o  out  1  pc_o is a legal fetch address
- redirect_o  out  1  one-cycle pulse: PC changed non-sequentially (pipeline flush)
- misalign_o  out  1  misaligned target detected
- misalign_addr_o  out  XLEN  offending target

Behaviour:
- Reset (rst=0 at posedge): pc_o=RESET_VECTOR, pc_prev_o=RESET_VECTOR, pc_valid_o=0, redirect_o=0, misalign_o=0, misalign_addr_o=0; FSM enters BOOT.
- FSM states:
  - BOOT: one cycle; pc_valid_o rises at the next edge; goes to RUN.
  - RUN: normal operation.
  - HALT: misaligned target taken; PC frozen, pc_valid_o=0, misalign_o held high; exit only by reset.
- RUN priority, evaluated at each posedge: branch (br_taken) > jal > jalr > stall > !imem_ready > sequential.
- Redirects override stall and imem_ready=0. Selected target T:
  - T aligned: pc_o<=T, pc_prev_o<=old pc_o, redirect_o=1 for exactly the following cycle.
  - T misaligned (C_EXT=0: T[1:0]!=0; C_EXT=1: T[0]!=0; jalr bit 0 cleared first so only bit 1 can fault): pc_o unchanged, misalign_addr_o<=T, misalign_o<=1, go to HALT.
- stall=1 with no redirect: pc_o and pc_prev_o hold.
- imem_ready=0 with no redirect and no stall: pc_o and pc_prev_o hold.
- Sequential: pc_o<=pc_o+STEP modulo 2^XLEN (wraps from all-ones region to low addresses, no flag); pc_prev_o<=old pc_o.
- Simultaneous redirect requests: lower-priority ones are dropped, not queued.
- Reset mid-operation (any state, including HALT or during stall) returns to the reset values next edge.
- Latency: one cycle from redirect input to new pc_o; zero added bubbles.

Optional Feature:
- Macro: PC_TRAP_EN.
- Defined: adds ports trap_i (1), trap_vec_i (XLEN), mret_i (1), mepc_i (XLEN). Priority becomes trap > mret > branch > jal > jalr > stall > imem > sequential; trap/mret redirect like any other (redirect_o pulse).
- Defined, misaligned target: no HALT; pc_o<=trap_vec_i the same edge, misalign_o pulses one cycle, misalign_addr_o captured, FSM stays RUN. trap_vec_i/mepc_i low two bits are forced to 0.
- Undefined: ports absent; HALT behaviour as above.

Test Plan:
- Reset release with RESET_VECTOR=32'h100, imem_ready=1 -> pc_o 0x100 (valid low) for BOOT, then 0x104, 0x108; pc_prev_o trails by one.
- stall=1 for 3 cycles at pc 0x20 -> pc_o=0x20, pc_prev_o=0x1C throughout; resumes at 0x24.
- br_taken=1 target 0x80 plus jal=1 target 0x40, with stall=1, same cycle -> pc_o=0x80, redirect_o one-cycle pulse, pc_prev_o=old pc.
- jalr target 0x203 (C_EXT=0) -> bit 0 cleared to 0x202, misaligned -> misalign_o=1, misalign_addr_o=0x202, HALT, pc_valid_o=0 until reset.
- pc_o=32'hFFFF_FFFC, sequential -> pc_o=0x0, no flag; imem_ready=0 at 0x0 -> hold until ready.
- PC_TRAP_EN: branch to 0x42 with trap_vec_i=0x300 -> pc_o=0x300, misalign_o pulse; then mret_i with mepc_i=0x44 -> pc_o=0x44.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the RV32I fetch stage.
//   Holds the fetch PC and the PC of the previously fetched instruction,
//   resolves branch/jal/jalr redirects, freezes on data-side stall or
//   instruction-memory back-pressure, and detects misaligned targets.
//
// Optional feature macro: PC_TRAP_EN
//   Adds trap/mret redirects. A misaligned target then vectors to trap_vec_i
//   instead of halting.
//
// Ports:
//   clk                 clock, all state on rising edge
//   rst                 synchronous active-low reset
//   stall               data-side stall, freezes pc_o and pc_prev_o
//   imem_ready          instruction memory accepted pc_o
//   br_taken/br_target  taken branch and its target
//   jal/jal_target      jal redirect and its target
//   jalr/jalr_target    jalr redirect and its target (bit 0 cleared)
//   trap_i/trap_vec_i   trap redirect and vector      (PC_TRAP_EN only)
//   mret_i/mepc_i       mret redirect and return PC   (PC_TRAP_EN only)
//   pc_o                current fetch PC
//   pc_prev_o           PC of the previously fetched instruction
//   pc_valid_o          pc_o is a legal fetch address
//   redirect_o          one-cycle pulse after a non-sequential PC change
//   misalign_o          misaligned target detected
//   misalign_addr_o     offending target
//
// FSM states:
//   state  | meaning
//   S_BOOT | first cycle after reset, PC held, pc_valid_o rises on exit
//   S_RUN  | normal fetch: redirect, hold or sequential advance
//   S_HALT | misaligned target taken, everything frozen until reset

module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     STEP         = 4,
  parameter int unsigned     C_EXT        = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            imem_ready,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jal,
  input  logic [XLEN-1:0] jal_target,
  input  logic            jalr,
  input  logic [XLEN-1:0] jalr_target,
`ifdef PC_TRAP_EN
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mepc_i,
`endif
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_prev_o,
  output logic            pc_valid_o,
  output logic            redirect_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, r_prev, r_maddr;
  logic            r_valid, r_redir, r_mis;
  logic [XLEN-1:0] w_pc_nxt, w_prev_nxt, w_maddr_nxt;
  logic            w_valid_nxt, w_redir_nxt, w_mis_nxt;

  logic            w_req;
  logic [XLEN-1:0] w_tgt;
  logic [XLEN-1:0] w_jalr_tgt;
  logic            w_misalign;

  assign w_jalr_tgt = jalr_target & ~XLEN'(1);

`ifdef PC_TRAP_EN
  logic [XLEN-1:0] w_trap_vec, w_mepc;
  assign w_trap_vec = trap_vec_i & ~XLEN'(3);
  assign w_mepc     = mepc_i & ~XLEN'(3);
`endif

  // Requests are applied lowest priority first so the highest-priority
  // asserted request is the one left in w_tgt; the others are dropped.
  always_comb begin
    w_req = 1'b0;
    w_tgt = '0;
    if (jalr) begin
      w_req = 1'b1;
      w_tgt = w_jalr_tgt;
    end
    if (jal) begin
      w_req = 1'b1;
      w_tgt = jal_target;
    end
    if (br_taken) begin
      w_req = 1'b1;
      w_tgt = br_target;
    end
`ifdef PC_TRAP_EN
    if (mret_i) begin
      w_req = 1'b1;
      w_tgt = w_mepc;
    end
    if (trap_i) begin
      w_req = 1'b1;
      w_tgt = w_trap_vec;
    end
`endif
  end

  assign w_misalign = (C_EXT != 0) ? w_tgt[0] : (w_tgt[1:0] != 2'b00);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_prev_nxt  = r_prev;
    w_valid_nxt = r_valid;
    w_redir_nxt = 1'b0;
    w_mis_nxt   = r_mis;
    w_maddr_nxt = r_maddr;
    unique case (r_state)
      S_BOOT: begin
        w_valid_nxt = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // In the trap build misalign_o is a single-cycle pulse.
        w_mis_nxt = 1'b0;
        if (w_req && !w_misalign) begin
          w_pc_nxt    = w_tgt;
          w_prev_nxt  = r_pc;
          w_redir_nxt = 1'b1;
        end else if (w_req) begin
          w_mis_nxt   = 1'b1;
          w_maddr_nxt = w_tgt;
`ifdef PC_TRAP_EN
          w_pc_nxt    = w_trap_vec;
          w_prev_nxt  = r_pc;
          w_redir_nxt = 1'b1;
`else
          w_valid_nxt = 1'b0;
          w_state_nxt = S_HALT;
`endif
        end else if (!stall && imem_ready) begin
          w_pc_nxt   = r_pc + XLEN'(STEP);
          w_prev_nxt = r_pc;
        end
      end
      S_HALT: begin
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_VECTOR;
      r_prev  <= RESET_VECTOR;
      r_valid <= 1'b0;
      r_redir <= 1'b0;
      r_mis   <= 1'b0;
      r_maddr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_prev  <= w_prev_nxt;
      r_valid <= w_valid_nxt;
      r_redir <= w_redir_nxt;
      r_mis   <= w_mis_nxt;
      r_maddr <= w_maddr_nxt;
    end
  end

  assign pc_o            = r_pc;
  assign pc_prev_o       = r_prev;
  assign pc_valid_o      = r_valid;
  assign redirect_o      = r_redir;
  assign misalign_o      = r_mis;
  assign misalign_addr_o = r_maddr;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed vector table, trap sequence (PC_TRAP_EN
// builds) and randomized stimulus against a behavioural model.

module tb_pc_unit;

  localparam int unsigned XLEN  = 32;
  localparam logic [31:0] RV    = 32'h100;
  localparam int unsigned STEP  = 4;
  localparam int unsigned C_EXT = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, imem_ready, br_taken, jal, jalr;
  logic [31:0] br_target, jal_target, jalr_target;
  logic        trap_i, mret_i;
  logic [31:0] trap_vec_i, mepc_i;
  logic [31:0] pc_o, pc_prev_o, misalign_addr_o;
  logic        pc_valid_o, redirect_o, misalign_o;

  pc_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .STEP(STEP), .C_EXT(C_EXT)) dut (
    .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
    .br_taken(br_taken), .br_target(br_target),
    .jal(jal), .jal_target(jal_target),
    .jalr(jalr), .jalr_target(jalr_target),
`ifdef PC_TRAP_EN
    .trap_i(trap_i), .trap_vec_i(trap_vec_i), .mret_i(mret_i), .mepc_i(mepc_i),
`endif
    .pc_o(pc_o), .pc_prev_o(pc_prev_o), .pc_valid_o(pc_valid_o),
    .redirect_o(redirect_o), .misalign_o(misalign_o),
    .misalign_addr_o(misalign_addr_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] e_pc, input logic [31:0] e_prev,
                            input logic e_valid, input logic e_redir, input logic e_mis,
                            input logic [31:0] e_maddr);
    check($sformatf("%s.pc", tag), pc_o, e_pc);
    check($sformatf("%s.prev", tag), pc_prev_o, e_prev);
    check($sformatf("%s.valid", tag), 32'(pc_valid_o), 32'(e_valid));
    check($sformatf("%s.redirect", tag), 32'(redirect_o), 32'(e_redir));
    check($sformatf("%s.misalign", tag), 32'(misalign_o), 32'(e_mis));
    check($sformatf("%s.maddr", tag), misalign_addr_o, e_maddr);
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_pc, m_prev, m_maddr;
  logic        m_valid, m_redir, m_mis, m_boot, m_halt;

  function automatic bit is_misaligned(input logic [31:0] t);
    if (C_EXT != 0) return t[0];
    return t[1:0] != 2'b00;
  endfunction

  task automatic model_step();
    logic [31:0] t;
    bit          have;
    if (!rst) begin
      m_pc = RV; m_prev = RV; m_valid = 1'b0; m_redir = 1'b0;
      m_mis = 1'b0; m_maddr = '0; m_boot = 1'b1; m_halt = 1'b0;
      return;
    end
    m_redir = 1'b0;
    if (m_boot) begin
      m_boot  = 1'b0;
      m_valid = 1'b1;
      return;
    end
    if (m_halt) return;
    m_mis = 1'b0;
    have  = 1'b1;
    t     = '0;
    if (trap_i)        t = trap_vec_i & 32'hFFFF_FFFC;
    else if (mret_i)   t = mepc_i & 32'hFFFF_FFFC;
    else if (br_taken) t = br_target;
    else if (jal)      t = jal_target;
    else if (jalr)     t = {jalr_target[31:1], 1'b0};
    else               have = 1'b0;
    if (have) begin
      if (is_misaligned(t)) begin
        m_mis   = 1'b1;
        m_maddr = t;
`ifdef PC_TRAP_EN
        m_prev  = m_pc;
        m_pc    = trap_vec_i & 32'hFFFF_FFFC;
        m_redir = 1'b1;
`else
        m_halt  = 1'b1;
        m_valid = 1'b0;
`endif
      end else begin
        m_prev  = m_pc;
        m_pc    = t;
        m_redir = 1'b1;
      end
    end else if (!stall && imem_ready) begin
      m_prev = m_pc;
      m_pc   = m_pc + STEP;
    end
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 15) == 0) t = t | 32'($urandom_range(1, 3));
    return t;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, stall, rdy, br;
    logic [31:0] bt;
    logic        jal;
    logic [31:0] jt;
    logic        jalr;
    logic [31:0] jrt;
    logic [31:0] e_pc, e_prev;
    logic        e_valid, e_redir, e_mis;
    logic [31:0] e_maddr;
  } vec_t;

  localparam int NV = 28;
  vec_t vec [NV];

  initial begin
    rst = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    br_taken = 1'b0; jal = 1'b0; jalr = 1'b0;
    br_target = '0; jal_target = '0; jalr_target = '0;
    trap_i = 1'b0; mret_i = 1'b0; trap_vec_i = '0; mepc_i = '0;

    //          rst   stall rdy   br    bt            jal   jt            jalr  jrt         pc            prev          val   red   mis   maddr
    vec[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,      32'h100,      32'h100,      1'b0, 1'b0, 1'b0, 32'h0};
    vec[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,      32'h100,      32'h100,      1'b1, 1'b0, 1'b0, 32'h0};
    vec[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,      32'h104,      32'h100,      1'b1, 1'b0, 1'b0, 32'h0};
    vec[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,      32'h108,      32'h104,      1'b1, 1'b0, 1'b0, 32'h0};
    vec[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1C,       1'b0, 32'h0,      32'h1C,       32'h108,      1'b1, 1'b1, 1'b0, 32'h0};
    vec[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,      32'h20,       32'h1C,       1'b1, 1'b0, 1'b0, 32'h0};
    vec[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,      32'h20,       32'h1C,       1'b1, 1'b0, 1'b0, 32'h0};
    vec[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,      32'h20,       32'h1C,       1'b1, 1'b0, 1'b0, 32'h0};
    vec[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,      32'h20,       32'h1C,       1'b1, 1'b0, 1'b0, 32'h0};
    vec[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,      32'h24,       32'h20,       1'b1, 1'b0, 1'b0, 32'h0};
    vec[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h80,       1'b1, 32'h40,       1'b0, 32'h0,      32'h80,       32'h24,       1'b1, 1'b1, 1'b0, 32'h0};
    vec[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,      32'h84,       32'h80,       1'b1, 1'b0, 1'b0, 32'h0};
    vec[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,     32'hFFFF_FFFC, 32'h84,      1'b1, 1'b1, 1'b0, 32'h0};
    vec[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,      32'h0,        32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0};
    vec[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,      32'h0,        32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0};
    vec[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,      32'h0,        32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0};
    vec[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,      32'h4,        32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
    vec[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h203,    32'h4,        32'h0,        1'b0, 1'b0, 1'b1, 32'h202};
    vec[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,      32'h4,        32'h0,        1'b0, 1'b0, 1'b1, 32'h202};
    vec[19] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h100,      1'b0, 32'h0,        1'b0, 32'h0,      32'h4,        32'h0,        1'b0, 1'b0, 1'b1, 32'h202};
    vec[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,      32'h100,      32'h100,      1'b0, 1'b0, 1'b0, 32'h0};
    vec[21] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,      32'h100,      32'h100,      1'b1, 1'b0, 1'b0, 32'h0};
    vec[22] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h201,    32'h200,      32'h100,      1'b1, 1'b1, 1'b0, 32'h0};
    vec[23] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h300,      1'b0, 32'h0,      32'h300,      32'h200,      1'b1, 1'b1, 1'b0, 32'h0};
    vec[24] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h306,      1'b0, 32'h0,        1'b0, 32'h0,      32'h300,      32'h200,      1'b0, 1'b0, 1'b1, 32'h306};
    vec[25] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,      32'h100,      32'h100,      1'b0, 1'b0, 1'b0, 32'h0};
    vec[26] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,      32'h100,      32'h100,      1'b1, 1'b0, 1'b0, 32'h0};
    vec[27] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h50,     32'h50,       32'h100,      1'b1, 1'b1, 1'b0, 32'h0};

`ifndef PC_TRAP_EN
    for (int i = 0; i < NV; i++) begin
      rst = vec[i].rst; stall = vec[i].stall; imem_ready = vec[i].rdy;
      br_taken = vec[i].br; br_target = vec[i].bt;
      jal = vec[i].jal; jal_target = vec[i].jt;
      jalr = vec[i].jalr; jalr_target = vec[i].jrt;
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", i), vec[i].e_pc, vec[i].e_prev, vec[i].e_valid,
                 vec[i].e_redir, vec[i].e_mis, vec[i].e_maddr);
    end
`else
    // Misaligned branch vectors to the trap address, then mret returns.
    rst = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    @(posedge clk); #1;
    check_outs("trap.reset", 32'h100, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_outs("trap.boot", 32'h100, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
    br_taken = 1'b1; br_target = 32'h42; trap_vec_i = 32'h300;
    @(posedge clk); #1;
    check_outs("trap.misalign", 32'h300, 32'h100, 1'b1, 1'b1, 1'b1, 32'h42);
    br_taken = 1'b0; mret_i = 1'b1; mepc_i = 32'h44;
    @(posedge clk); #1;
    check_outs("trap.mret", 32'h44, 32'h300, 1'b1, 1'b1, 1'b0, 32'h42);
    mret_i = 1'b0; trap_i = 1'b1; trap_vec_i = 32'h403; br_taken = 1'b1; br_target = 32'h80;
    @(posedge clk); #1;
    check_outs("trap.prio", 32'h400, 32'h44, 1'b1, 1'b1, 1'b0, 32'h42);
    trap_i = 1'b0; br_taken = 1'b0;
`endif

    // ---------------- randomized phase ----------------
    for (int i = 0; i < 1500; i++) begin
      rst         = (i == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
      stall       = ($urandom_range(0, 3) == 0);
      imem_ready  = ($urandom_range(0, 3) != 0);
      br_taken    = ($urandom_range(0, 7) == 0);
      br_target   = rand_tgt();
      jal         = ($urandom_range(0, 7) == 0);
      jal_target  = rand_tgt();
      jalr        = ($urandom_range(0, 7) == 0);
      jalr_target = rand_tgt() | 32'($urandom_range(0, 1));
`ifdef PC_TRAP_EN
      trap_i      = ($urandom_range(0, 31) == 0);
      mret_i      = ($urandom_range(0, 31) == 0);
      trap_vec_i  = $urandom;
      mepc_i      = $urandom;
`endif
      model_step();
      @(posedge clk); #1;
      check_outs($sformatf("rnd%0d", i), m_pc, m_prev, m_valid, m_redir, m_mis, m_maddr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
